// File: rtl/merge3_rr_sched.sv
// Three-way byte-stream merge node: per-channel FIFOs drained round-robin onto one stream.
// Optional per-channel saturating drop counters when MERGE3_DROP_CNT_EN is defined.
module merge3_rr_sched #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          wen0,
    input  logic          wen1,
    input  logic          wen2,
    input  logic [DW-1:0] i_data0,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic          ren,
    output logic          valid,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_grant,
    output logic [2:0]    o_full,
`ifdef MERGE3_DROP_CNT_EN
    output logic [7:0]    o_drop_cnt0,
    output logic [7:0]    o_drop_cnt1,
    output logic [7:0]    o_drop_cnt2,
`endif
    output logic [2:0]    o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Channel search order starts just after the last grant.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] ne);
        logic [1:0] g;
        g = 2'd0;
        case (last)
            2'd0: begin
                if (ne[1]) g = 2'd1;
                else if (ne[2]) g = 2'd2;
                else g = 2'd0;
            end
            2'd1: begin
                if (ne[2]) g = 2'd2;
                else if (ne[0]) g = 2'd0;
                else g = 2'd1;
            end
            default: begin
                if (ne[0]) g = 2'd0;
                else if (ne[1]) g = 2'd1;
                else g = 2'd2;
            end
        endcase
        return g;
    endfunction

    logic [DW-1:0] mem_r    [3][DEPTH];
    logic [AW-1:0] wr_ptr_r [3];
    logic [AW-1:0] rd_ptr_r [3];
    logic [AW:0]   count_r  [3];
    logic [AW:0]   cnt_nxt_s[3];
    logic [1:0]    last_r;
    state_t        state_r;
    logic          valid_r;
    logic [DW-1:0] data_r;
    logic [1:0]    grant_r;
    logic [2:0]    ovf_r;

    logic [2:0]    wen_s;
    logic [DW-1:0] wdata_s [3];
    logic [2:0]    full_s;
    logic [2:0]    nonempty_s;
    logic [2:0]    wr_ok_s;
    logic [2:0]    drop_s;
    logic [2:0]    pop_ch_s;
    logic          pop_s;
    logic          any_next_s;
    logic [1:0]    grant_s;
    logic [DW-1:0] head_s;

    // Per-channel status, grant selection and next-count computation.
    always_comb begin
        wen_s      = {wen2, wen1, wen0};
        wdata_s[0] = i_data0;
        wdata_s[1] = i_data1;
        wdata_s[2] = i_data2;
        full_s     = 3'b000;
        nonempty_s = 3'b000;
        for (int n = 0; n < 3; n++) begin
            full_s[n]     = (count_r[n] == FULL_CNT);
            nonempty_s[n] = (count_r[n] != '0);
        end
        // Full is judged on the registered count, so a write to a full FIFO drops even if it pops.
        wr_ok_s    = wen_s & ~full_s;
        drop_s     = wen_s & full_s;
        pop_s      = ren && (|nonempty_s);
        grant_s    = rr_pick(last_r, nonempty_s);
        pop_ch_s   = 3'b000;
        any_next_s = 1'b0;
        for (int n = 0; n < 3; n++) begin
            pop_ch_s[n] = pop_s && (grant_s == 2'(n));
            case ({wr_ok_s[n], pop_ch_s[n]})
                2'b10:   cnt_nxt_s[n] = count_r[n] + (AW+1)'(1);
                2'b01:   cnt_nxt_s[n] = count_r[n] - (AW+1)'(1);
                default: cnt_nxt_s[n] = count_r[n];
            endcase
            any_next_s = any_next_s | (cnt_nxt_s[n] != '0);
        end
        case (grant_s)
            2'd0:    head_s = mem_r[0][rd_ptr_r[0]];
            2'd1:    head_s = mem_r[1][rd_ptr_r[1]];
            2'd2:    head_s = mem_r[2][rd_ptr_r[2]];
            default: head_s = '0;
        endcase
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset needed.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 3; n++) begin
            if (wr_ok_s[n]) begin
                mem_r[n][wr_ptr_r[n]] <= wdata_s[n];
            end
        end
    end

    // Pointers, counts and sticky overflow flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int n = 0; n < 3; n++) begin
                wr_ptr_r[n] <= '0;
                rd_ptr_r[n] <= '0;
                count_r[n]  <= '0;
            end
            ovf_r <= 3'b000;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (wr_ok_s[n]) wr_ptr_r[n] <= wr_ptr_r[n] + AW'(1);
                if (pop_ch_s[n]) rd_ptr_r[n] <= rd_ptr_r[n] + AW'(1);
                count_r[n] <= cnt_nxt_s[n];
            end
            ovf_r <= ovf_r | drop_s;
        end
    end

    // Scheduler state and registered output stage.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
            last_r  <= 2'd2;
            valid_r <= 1'b0;
            data_r  <= '0;
            grant_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE:  if (|nonempty_s) state_r <= ST_SERVE;
                ST_SERVE: if (!any_next_s) state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
            if (pop_s) begin
                valid_r <= 1'b1;
                data_r  <= head_s;
                grant_r <= grant_s;
                last_r  <= grant_s;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

`ifdef MERGE3_DROP_CNT_EN
    logic [7:0] drop_cnt_r [3];

    // Saturating per-channel dropped-write counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int n = 0; n < 3; n++) drop_cnt_r[n] <= 8'd0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (drop_s[n] && (drop_cnt_r[n] != 8'hFF)) begin
                    drop_cnt_r[n] <= drop_cnt_r[n] + 8'd1;
                end
            end
        end
    end

    assign o_drop_cnt0 = drop_cnt_r[0];
    assign o_drop_cnt1 = drop_cnt_r[1];
    assign o_drop_cnt2 = drop_cnt_r[2];
`endif

    assign valid   = valid_r;
    assign o_data  = data_r;
    assign o_grant = grant_r;
    assign o_full  = full_s;
    assign o_ovf   = ovf_r;

endmodule

// File: tb/tb_merge3_rr_sched.sv
// Directed self-checking bench for merge3_rr_sched (DW=8, DEPTH=4).
module tb_merge3_rr_sched;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b1;
    logic       wen0 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
    logic [7:0] i_data0 = 8'h00, i_data1 = 8'h00, i_data2 = 8'h00;
    logic       ren = 1'b0;
    logic       valid;
    logic [7:0] o_data;
    logic [1:0] o_grant;
    logic [2:0] o_full;
    logic [2:0] o_ovf;
`ifdef MERGE3_DROP_CNT_EN
    logic [7:0] o_drop_cnt0, o_drop_cnt1, o_drop_cnt2;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    merge3_rr_sched #(.DW(8), .DEPTH(4)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .wen0    (wen0),
        .wen1    (wen1),
        .wen2    (wen2),
        .i_data0 (i_data0),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .ren     (ren),
        .valid   (valid),
        .o_data  (o_data),
        .o_grant (o_grant),
        .o_full  (o_full),
`ifdef MERGE3_DROP_CNT_EN
        .o_drop_cnt0 (o_drop_cnt0),
        .o_drop_cnt1 (o_drop_cnt1),
        .o_drop_cnt2 (o_drop_cnt2),
`endif
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] g);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) begin
            chk({tag, ".data"}, 32'(o_data), 32'(d));
            chk({tag, ".grant"}, 32'(o_grant), 32'(g));
        end
    endtask

    task automatic pulse_reset();
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
    endtask

    logic [7:0] rr_data [6];
    logic [1:0] rr_gnt  [6];

    initial begin
        rr_data = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21};
        rr_gnt  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        // Asynchronous reset asserted mid-cycle
        #2 i_rstn = 1'b0;
        #1;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.data",  32'(o_data), 32'd0);
        chk("rst.grant", 32'(o_grant), 32'd0);
        chk("rst.full",  32'(o_full), 32'd0);
        chk("rst.ovf",   32'(o_ovf), 32'd0);
`ifdef MERGE3_DROP_CNT_EN
        chk("rst.drop", 32'({o_drop_cnt0, o_drop_cnt1, o_drop_cnt2}), 32'd0);
`endif
        tick();
        i_rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle.valid", 32'(valid), 32'd0);
        end

        // Single word latency on channel 1
        ren = 1'b1;
        wen1 = 1'b1; i_data1 = 8'hA5;
        tick();
        wen1 = 1'b0;
        chk("single.no_same_edge", 32'(valid), 32'd0);
        tick();
        chk_out("single", 1'b1, 8'hA5, 2'd1);
        tick();
        chk("single.after", 32'(valid), 32'd0);

        // Round-robin across three preloaded channels
        pulse_reset();
        ren = 1'b0;
        wen0 = 1'b1; wen1 = 1'b1; wen2 = 1'b1;
        i_data0 = 8'h00; i_data1 = 8'h10; i_data2 = 8'h20;
        tick();
        i_data0 = 8'h01; i_data1 = 8'h11; i_data2 = 8'h21;
        tick();
        wen0 = 1'b0; wen1 = 1'b0; wen2 = 1'b0;
        chk("rr.stall_valid", 32'(valid), 32'd0);
        chk("rr.not_full", 32'(o_full), 32'd0);
        ren = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, rr_data[i], rr_gnt[i]);
        end
        tick();
        chk("rr.drained", 32'(valid), 32'd0);

        // Overflow on channel 0
        ren = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wen0 = 1'b1; i_data0 = 8'(i);
            tick();
            if (i == 4) begin
                chk("ovf.full4", 32'(o_full), 32'b001);
                chk("ovf.ovf4",  32'(o_ovf),  32'b000);
            end
        end
        wen0 = 1'b0;
        chk("ovf.ovf5",  32'(o_ovf),  32'b001);
        chk("ovf.full5", 32'(o_full), 32'b001);
`ifdef MERGE3_DROP_CNT_EN
        chk("ovf.drop0", 32'(o_drop_cnt0), 32'd1);
`endif
        ren = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_out($sformatf("ovf.out%0d", i), 1'b1, 8'(i), 2'd0);
        end
        tick();
        chk("ovf.no5th", 32'(valid), 32'd0);
        chk("ovf.sticky", 32'(o_ovf), 32'b001);

        // Write to full channel 2 on the same edge as a pop
        ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wen2 = 1'b1; i_data2 = 8'h30 + 8'(i);
            tick();
        end
        chk("fwp.full", 32'(o_full), 32'b100);
        ren = 1'b1;
        wen2 = 1'b1; i_data2 = 8'h77;
        tick();
        wen2 = 1'b0;
        chk_out("fwp.pop", 1'b1, 8'h30, 2'd2);
        chk("fwp.ovf", 32'(o_ovf), 32'b101);
        chk("fwp.notfull", 32'(o_full), 32'b000);
`ifdef MERGE3_DROP_CNT_EN
        chk("fwp.drop2", 32'(o_drop_cnt2), 32'd1);
`endif
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_out($sformatf("fwp.rest%0d", i), 1'b1, 8'h30 + 8'(i), 2'd2);
        end
        tick();
        chk("fwp.dropped", 32'(valid), 32'd0);

        // Reset with all FIFOs half full
        ren = 1'b0;
        wen0 = 1'b1; wen1 = 1'b1; wen2 = 1'b1;
        i_data0 = 8'hC0; i_data1 = 8'hC1; i_data2 = 8'hC2;
        tick();
        tick();
        wen0 = 1'b0; wen1 = 1'b0; wen2 = 1'b0;
        pulse_reset();
        chk("mrst.valid", 32'(valid), 32'd0);
        chk("mrst.full",  32'(o_full), 32'd0);
        chk("mrst.ovf",   32'(o_ovf), 32'd0);
        chk("mrst.data",  32'(o_data), 32'd0);
        ren = 1'b1;
        wen2 = 1'b1; i_data2 = 8'h5C;
        tick();
        wen2 = 1'b0;
        chk("mrst.wait", 32'(valid), 32'd0);
        tick();
        chk_out("mrst.first", 1'b1, 8'h5C, 2'd2);
        tick();
        chk("mrst.empty", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
